// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//   Serial UART receiver. 8N1 by default, LSB first. The rx line is oversampled
//   OVERSAMPLE times per bit. A byte is presented on rx_data together with a
//   one-clock rx_done strobe only when its stop bit is good. A bad stop bit
//   raises frame_err instead, and rx_data keeps its old value. A start bit that
//   is not still low at its midpoint counts as a false start. It returns the
//   FSM to IDLE without any pulse.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     When it is defined the frame is 8E1. A PARITY state sits between DATA and
//     STOP, and the extra output parity_err pulses for one clock when the
//     parity bit is wrong. A byte with a parity error never produces rx_done.
//
// Output pulses
//   rx_done, frame_err and parity_err are registered strobes, each exactly one
//   clock wide. There is no back-pressure: the consumer must take rx_data on
//   the cycle where rx_done is high. rx_data holds between frames.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous reset, active-low
//   rx         in   1  asynchronous serial input, idles high
//   rx_data    out  8  last correctly received byte
//   rx_done    out  1  1-clk pulse, rx_data just updated with a good byte
//   frame_err  out  1  1-clk pulse, stop bit sampled low
//   busy       out  1  high whenever the FSM is not in IDLE
//   parity_err out  1  (UART_RX_PARITY_EN only) 1-clk pulse, bad even parity
//
// Debug: the FSM state is held in state_q (type state_t). Checkers can reach it
// hierarchically.
// DIV = CLK_HZ/(BAUD*OVERSAMPLE) must be >= 2. OVERSAMPLE must be even and >= 8.
// -----------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLK_HZ     = 65_000_000,
  parameter int BAUD       = 9_600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // 2-FF synchronizer. The flops reset to the idle-high line level, so a
  // reset release can never be mistaken for a start bit.
  logic rx_m, rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Free-running oversample tick generator.
  logic [TW-1:0] t_cnt;
  logic          tick;

  assign tick = (t_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_cnt <= '0;
    else if (tick) t_cnt <= '0;
    else t_cnt <= t_cnt + 1'b1;
  end

  // FSM state and datapath registers.
  state_t        state_q, state_d;
  logic [SW-1:0] s_cnt_q, s_cnt_d;
  logic [2:0]    b_cnt_q, b_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rx_data_d;
  logic          done_d, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          perr_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      s_cnt_q    <= '0;
      b_cnt_q    <= '0;
      shreg_q    <= '0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      b_cnt_q    <= b_cnt_d;
      shreg_q    <= shreg_d;
      rx_data    <= rx_data_d;
      rx_done    <= done_d;
      frame_err  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      parity_err <= perr_d;
`endif
    end
  end

  // Next-state logic. Nothing moves except on tick cycles. The pulse
  // requests default to 0, so each registered strobe lasts exactly one clock.
  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    b_cnt_d   = b_cnt_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            s_cnt_d = '0;
          end
        end
        S_START: begin
          // Re-check the line half a bit after the falling edge. Anything
          // shorter is treated as noise.
          if (s_cnt_q == S_MID) begin
            if (!rx_s) begin
              state_d = S_DATA;
              s_cnt_d = '0;
              b_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (s_cnt_q == S_LAST) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            s_cnt_d = '0;
            if (b_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              b_cnt_d = b_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d   = '0;
            par_bad_d = ((^shreg_q) != rx_s);
            perr_d    = ((^shreg_q) != rx_s);
            state_d   = S_STOP;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            if (rx_s) begin
              state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (!par_bad_q) begin
                rx_data_d = shreg_q;
                done_d    = 1'b1;
              end
`else
              rx_data_d = shreg_q;
              done_d    = 1'b1;
`endif
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          // A line held low would otherwise look like endless start bits.
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
//   Bench for uart_rx_byte at CLK_HZ=1_600_000, BAUD=10_000, OVERSAMPLE=16. That
//   gives DIV=10 and a 160-clock bit period. The reference model works at frame
//   level. Every frame the driver sends is either good, in which case its byte
//   goes into exp_q and the good-byte count, or bad, in which case the
//   frame_err/parity_err counts go up. A monitor on the falling clock edge pops
//   exp_q on each rx_done and compares it with rx_data.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_byte #(
    .CLK_HZ(1_600_000),
    .BAUD(10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .frame_err(frame_err),
    .busy(busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;   // observed rx_done pulses
  int n_ferr   = 0;   // observed frame_err pulses
  int n_perr   = 0;   // observed parity_err pulses
  int done_exp = 0;   // model: good frames sent
  int ferr_exp = 0;   // model: bad-stop frames sent
  int perr_exp = 0;   // model: bad-parity frames sent
  logic [7:0] last_good = 8'h00;
  int busy_run = 0;
  int busy_max = 0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done) begin
        n_done++;
        check("rx_done_width", prev_done, 0);
        if (exp_q.size() > 0) check("rx_data", rx_data, exp_q.pop_front());
        else check("rx_done_spurious", rx_done, 0);
      end
      if (frame_err) n_ferr++;
      if (rx_done || frame_err) check("done_ferr_excl", rx_done & frame_err, 0);
`ifdef UART_RX_PARITY_EN
      if (parity_err) begin
        n_perr++;
        check("perr_done_excl", rx_done, 0);
      end
`endif
      if (busy) begin
        busy_run++;
        if (busy_run > busy_max) busy_max = busy_run;
      end else begin
        busy_run = 0;
      end
    end
    prev_done = rx_done;
  end

  // ---------------- driver tasks ----------------
  // par_flip: 1 sends the wrong even-parity bit (parity builds only).
  // rst_bit: index into the frame (0 = start bit) at which a 3-clock reset
  // pulse is fired. -1 means no reset.
  task automatic send_frame(input logic [7:0] data, input int bit_clks,
                            input logic stop_bit, input logic par_flip,
                            input int rst_bit);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back((^data) ^ par_flip);
`else
    if (par_flip) bits.push_back(1'b1);  // unused in 8N1 builds
`endif
    bits.push_back(stop_bit);
    for (int i = 0; i < bits.size(); i++) begin
      rx = bits[i];
      if (i == rst_bit) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_rx_done", rx_done, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_busy", busy, 0);
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        last_good = 8'h00;
        repeat (bit_clks - 3) @(posedge clk);
      end else begin
        repeat (bit_clks) @(posedge clk);
      end
    end
  endtask

  task automatic send_good(input logic [7:0] data, input int bit_clks);
    exp_q.push_back(data);
    done_exp++;
    last_good = data;
    send_frame(data, bit_clks, 1'b1, 1'b0, -1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  // Bounded wait for the receiver to go idle with nothing left in the queue.
  task automatic drain(input string tag);
    for (int i = 0; i < 4000 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    check({"drain_", tag}, exp_q.size(), 0);
    check({"counts_done_", tag}, n_done, done_exp);
    check({"counts_ferr_", tag}, n_ferr, ferr_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    int per;
    logic bad_stop;
    logic bad_par;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    rst_n = 1'b1;
    idle(50);

    // 1. Back-to-back frames with no idle gap.
    send_good(8'hA5, BIT);
    send_good(8'h3C, BIT);
    idle(50);
    drain("b2b");
    check("b2b_rx_data", rx_data, 8'h3C);

    // 2. 60-clock glitch: a false start, so no pulses and busy stays brief.
    busy_max = 0;
    rx = 1'b0;
    repeat (60) @(posedge clk);
    idle(300);
    drain("glitch");
    check("glitch_seen", busy_max > 0, 1);
    check("glitch_busy_lt100", busy_max < 100, 1);

    // 3. Bad stop bit, then a held-low break, then a good frame.
    ferr_exp++;
    send_frame(8'h55, BIT, 1'b0, 1'b0, -1);
    for (int k = 0; k < 4; k++) begin
      repeat (500) @(posedge clk);
      @(negedge clk);
      check("break_busy", busy, 1);
    end
    idle(40);
    @(negedge clk);
    check("break_released", busy, 0);
    check("ferr_rx_data_kept", rx_data, 8'h3C);
    check("ferr_count", n_ferr, ferr_exp);
    send_good(8'h12, BIT);
    idle(50);
    drain("break");

    // 4. Reset during bit 4 of 0xFF, then a good frame.
    send_frame(8'hFF, BIT, 1'b1, 1'b0, 5);
    n_done = done_exp;  // pulse counters restart with the DUT's reset
    idle(100);
    drain("midrst");
    send_good(8'h81, BIT);
    idle(50);
    drain("post_rst");
    check("post_rst_rx_data", rx_data, 8'h81);

    // 5. Baud skew of -5% and +5%.
    send_good(8'h96, 152);
    idle(200);
    send_good(8'h96, 168);
    idle(200);
    drain("skew");

`ifdef UART_RX_PARITY_EN
    // 6. Wrong parity, then correct parity.
    perr_exp++;
    send_frame(8'h07, BIT, 1'b1, 1'b1, -1);
    idle(50);
    drain("par_bad");
    check("par_bad_rx_data", rx_data, 8'h96);
    send_good(8'h07, BIT);
    idle(50);
    drain("par_good");
`endif

    // Randomized frames: random data, bit period, gap and fault injection.
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom_range(0, 255));
      per = $urandom_range(156, 164);
      bad_stop = ($urandom_range(0, 4) == 0);
      bad_par = 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_par = ($urandom_range(0, 4) == 0);
`endif
      if (bad_stop || bad_par) begin
        if (bad_stop) ferr_exp++;
        if (bad_par) perr_exp++;
        send_frame(d, per, ~bad_stop, bad_par, -1);
        if (bad_stop) repeat ($urandom_range(200, 600)) @(posedge clk);
      end else begin
        send_good(d, per);
      end
      idle($urandom_range(20, 60));
    end
    idle(100);
    drain("random");
    check("final_rx_data", rx_data, last_good);
    check("final_perr", n_perr, perr_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
